// File: rtl/rx_demod_if.sv
// Signal bundle between the DCSK chip source and the rx_demod receiver.
interface rx_demod_if;
  logic        i_start;
  logic        i_rx;
  logic [4:0]  i_sf;
  logic        o_bit;
  logic        o_bit_valid;
  logic [4:0]  o_corr;
  logic [31:0] o_msg;
  logic        o_msg_valid;
  logic        o_busy;

  modport master (
    output i_start, i_rx, i_sf,
    input  o_bit, o_bit_valid, o_corr, o_msg, o_msg_valid, o_busy
  );

  modport slave (
    input  i_start, i_rx, i_sf,
    output o_bit, o_bit_valid, o_corr, o_msg, o_msg_valid, o_busy
  );
endinterface

// File: rtl/rx_demod.sv
// DCSK receive demodulator: buffers each reference half, correlates it with the
// data half, decides one bit per frame and assembles a 32-bit message MSB first.
module rx_demod (
  input  logic     i_clk,
  input  logic     i_arst_n,
  rx_demod_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

  state_t      state;
  logic [4:0]  sf_q;
  logic [3:0]  chip_idx;
  logic [4:0]  bit_idx;
  logic [4:0]  agree;
  logic [15:0] ref_buf;
  logic [31:0] shreg;

  logic        sf_ok;
  logic        chip_last;
  logic        match;
  logic [4:0]  agree_nxt;
  logic [5:0]  agree_x2;
  logic        dec;

  // Decision includes the current (last) data chip; a tie (2A == SF) decides 0.
  always_comb begin
    sf_ok     = (bus.i_sf >= 5'd2) && (bus.i_sf <= 5'd16);
    chip_last = ({1'b0, chip_idx} == (sf_q - 5'd1));
    match     = (bus.i_rx == ref_buf[chip_idx]);
    agree_nxt = agree + {4'd0, match};
    agree_x2  = {agree_nxt, 1'b0};
    dec       = (agree_x2 > {1'b0, sf_q});
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state           <= IDLE;
      sf_q            <= '0;
      chip_idx        <= '0;
      bit_idx         <= '0;
      agree           <= '0;
      ref_buf         <= '0;
      shreg           <= '0;
      bus.o_bit       <= 1'b0;
      bus.o_bit_valid <= 1'b0;
      bus.o_corr      <= '0;
      bus.o_msg       <= '0;
      bus.o_msg_valid <= 1'b0;
      bus.o_busy      <= 1'b0;
    end else begin
      bus.o_bit_valid <= 1'b0;
      bus.o_msg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start && sf_ok) begin
            sf_q        <= bus.i_sf;
            ref_buf[0]  <= bus.i_rx;
            chip_idx    <= 4'd1;
            bit_idx     <= '0;
            agree       <= '0;
            bus.o_busy  <= 1'b1;
            state       <= REF;
          end
        end
        REF: begin
          ref_buf[chip_idx] <= bus.i_rx;
          if (chip_last) begin
            chip_idx <= '0;
            state    <= DATA;
          end else begin
            chip_idx <= chip_idx + 4'd1;
          end
        end
        DATA: begin
          if (chip_last) begin
            bus.o_bit       <= dec;
            bus.o_corr      <= agree_nxt;
            bus.o_bit_valid <= 1'b1;
            shreg           <= {shreg[30:0], dec};
            bit_idx         <= bit_idx + 5'd1;
            agree           <= '0;
            chip_idx        <= '0;
            if (bit_idx == 5'd31) begin
              bus.o_msg       <= {shreg[30:0], dec};
              bus.o_msg_valid <= 1'b1;
              bus.o_busy      <= 1'b0;
              state           <= IDLE;
            end else begin
              state <= REF;
            end
          end else begin
            agree    <= agree_nxt;
            chip_idx <= chip_idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_demod.sv
// Directed bench for rx_demod: builds DCSK frames from known messages and
// checks every decision, the completed word and its timing.
module tb_rx_demod;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  logic [31:0] last_msg;
  int   t1, t2;

  rx_demod_if bus ();

  rx_demod dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic refchip(input int k, input int j);
    return ((k * 5 + j * 3 + j / 2) % 3) == 0;
  endfunction

  function automatic int nflip(input logic [15:0] fm, input int sf, input int ff, input int k);
    int n;
    n = 0;
    if (ff >= 0 && ff != k) return 0;
    for (int i = 0; i < sf; i++) if (fm[i]) n++;
    return n;
  endfunction

  function automatic int exp_corr(input logic [31:0] msg, input int sf, input logic [15:0] fm,
                                  input int ff, input int k);
    int n;
    n = nflip(fm, sf, ff, k);
    return msg[31 - k] ? (sf - n) : n;
  endfunction

  function automatic logic exp_bit(input logic [31:0] msg, input int sf, input logic [15:0] fm,
                                   input int ff, input int k);
    return (2 * exp_corr(msg, sf, fm, ff, k)) > sf;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] msg, input int sf,
                                           input logic [15:0] fm, input int ff);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 32; k++) w[31 - k] = exp_bit(msg, sf, fm, ff, k);
    return w;
  endfunction

  // Streams one message starting at the current negedge; inputs change on
  // negedges, outputs from the preceding posedge are checked first.
  task automatic stream(input logic [31:0] msg, input int sf, input logic [15:0] fm,
                        input int ff, input int xs, input int sf_alt, input int abort_c);
    int   k, j;
    logic rc, d;
    for (int c = 0; c < 64 * sf; c++) begin
      if (c > 0) begin
        chk("busy", bus.o_busy, 1);
        chk("msg_valid_low", bus.o_msg_valid, 0);
        if (c % (2 * sf) == 0) begin
          k = c / (2 * sf) - 1;
          chk("bit_valid", bus.o_bit_valid, 1);
          chk("bit", bus.o_bit, exp_bit(msg, sf, fm, ff, k));
          chk("corr", bus.o_corr, exp_corr(msg, sf, fm, ff, k));
          chk("msg_hold", bus.o_msg, last_msg);
        end else begin
          chk("bit_valid_low", bus.o_bit_valid, 0);
        end
      end
      if (c == abort_c) begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        #1;
        chk("rst_bit", bus.o_bit, 0);
        chk("rst_bit_valid", bus.o_bit_valid, 0);
        chk("rst_corr", bus.o_corr, 0);
        chk("rst_msg", bus.o_msg, 0);
        chk("rst_msg_valid", bus.o_msg_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        last_msg = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      k  = c / (2 * sf);
      j  = c % (2 * sf);
      rc = refchip(k, j % sf);
      if (j < sf) begin
        d = rc;
      end else begin
        d = msg[31 - k] ? rc : ~rc;
        if (fm[j - sf] && (ff < 0 || ff == k)) d = ~d;
      end
      bus.i_rx    = d;
      bus.i_start = (c == 0) || (c == xs);
      bus.i_sf    = (c == 0) ? sf[4:0] : sf_alt[4:0];
      @(negedge clk);
    end
  endtask

  task automatic finish_msg(input logic [31:0] msg, input int sf, input logic [15:0] fm,
                            input int ff);
    logic [31:0] w;
    w = exp_word(msg, sf, fm, ff);
    chk("end_bit_valid", bus.o_bit_valid, 1);
    chk("end_bit", bus.o_bit, exp_bit(msg, sf, fm, ff, 31));
    chk("end_corr", bus.o_corr, exp_corr(msg, sf, fm, ff, 31));
    chk("end_msg_valid", bus.o_msg_valid, 1);
    chk("end_msg", bus.o_msg, w);
    chk("end_busy", bus.o_busy, 0);
    last_msg    = w;
    bus.i_start = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    last_msg    = '0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_rx    = 1'b0;
    bus.i_sf    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_bit", bus.o_bit, 0);
    chk("reset_bit_valid", bus.o_bit_valid, 0);
    chk("reset_corr", bus.o_corr, 0);
    chk("reset_msg", bus.o_msg, 0);
    chk("reset_msg_valid", bus.o_msg_valid, 0);
    chk("reset_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // SF=4 clean channel
    stream(32'hA5A5_0F0F, 4, 16'h0000, -1, -1, 4, -1);
    finish_msg(32'hA5A5_0F0F, 4, 16'h0000, -1);
    chk("sf4_word", last_msg, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("idle_after_sf4", bus.o_msg_valid, 0);

    // SF=16 then SF=2 back-to-back with zero gap
    stream(32'hFFFF_FFFF, 16, 16'h0000, -1, -1, 16, -1);
    finish_msg(32'hFFFF_FFFF, 16, 16'h0000, -1);
    t1 = cyc;
    stream(32'h0000_0001, 2, 16'h0000, -1, -1, 2, -1);
    finish_msg(32'h0000_0001, 2, 16'h0000, -1);
    t2 = cyc;
    chk("b2b_gap", t2 - t1, 128);
    chk("b2b_word", bus.o_msg, 32'h0000_0001);
    @(negedge clk);

    // SF=8 with chips 0-2 of every data half flipped: decisions survive
    stream(32'h1234_5678, 8, 16'h0007, -1, -1, 8, -1);
    finish_msg(32'h1234_5678, 8, 16'h0007, -1);
    chk("noisy_word", bus.o_msg, 32'h1234_5678);
    @(negedge clk);

    // SF=8 tie: 4 flips in frame 0 of a 1-bit decide 0
    stream(32'h8000_0000, 8, 16'h000F, 0, -1, 8, -1);
    finish_msg(32'h8000_0000, 8, 16'h000F, 0);
    chk("tie_word", bus.o_msg, 32'h0000_0000);
    @(negedge clk);

    // Illegal spreading factors are ignored
    bus.i_start = 1'b1; bus.i_sf = 5'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("sf1_busy", bus.o_busy, 0);
    bus.i_start = 1'b1; bus.i_sf = 5'd17;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("sf17_busy", bus.o_busy, 0);
    bus.i_start = 1'b1; bus.i_sf = 5'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("sf0_busy", bus.o_busy, 0);
    @(negedge clk);
    chk("illegal_busy_later", bus.o_busy, 0);

    // Mid-message start pulse and i_sf change both have no effect
    stream(32'hC3C3_5AA5, 4, 16'h0000, -1, 37, 8, -1);
    finish_msg(32'hC3C3_5AA5, 4, 16'h0000, -1);
    chk("midstart_word", bus.o_msg, 32'hC3C3_5AA5);
    @(negedge clk);

    // Reset at frame 10 aborts; no completion follows
    stream(32'hDEAD_BEEF, 4, 16'h0000, -1, -1, 4, 10 * 2 * 4);
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_msg_valid", bus.o_msg_valid, 0);
      chk("post_rst_msg", bus.o_msg, 0);
      chk("post_rst_busy", bus.o_busy, 0);
      @(negedge clk);
    end

    // Fresh start after reset
    stream(32'h0F1E_2D3C, 6, 16'h0000, -1, -1, 6, -1);
    finish_msg(32'h0F1E_2D3C, 6, 16'h0000, -1);
    chk("fresh_word", bus.o_msg, 32'h0F1E_2D3C);
    @(negedge clk);
    chk("fresh_idle", bus.o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_demod.md
# rx_demod

DCSK receive demodulator: the receive-side counterpart of the transmit chain. Consumes the one-chip-per-clock serial DCSK stream, buffers each frame's reference half, correlates it against the following data half, and decides one message bit per frame. After 32 frames it presents the recovered 32-bit message word. No chaos generator or seed is needed on this side.

## Interface
- No parameters. Message width is fixed at 32 bits. The maximum half-frame length is fixed at 16 chips.
- i_clk  in  1  system clock; one chip per cycle.
- i_arst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame-sync pulse; marks that the current i_rx chip is chip 0 of the first frame.
- i_rx  in  1  serial chip stream (transmitter line output).
- i_sf  in  5  spreading factor = chips per half-frame; legal range 2..16.
- o_bit  out  1  most recently decided message bit.
- o_bit_valid  out  1  one-cycle pulse when o_bit updates.
- o_corr  out  5  agreement count (0..16) behind the latest decision; valid with o_bit_valid.
- o_msg  out  32  last completed message word.
- o_msg_valid  out  1  one-cycle pulse when o_msg updates.
- o_busy  out  1  high while a message is being received.

## Operation
- Modulation convention: a frame is SF reference chips followed by SF data chips.
  - Each data chip equals the corresponding reference chip when the message bit is 1.
  - Each data chip is the inverted reference chip when the message bit is 0.
- Message bits are sent MSB first, so frame 0 carries o_msg[31].
- FSM states are IDLE, REF and DATA.
  - IDLE: i_start=1 with a legal i_sf latches SF into sf_q, captures the chip, and moves to REF with chip index 1.
  - IDLE: i_start with an illegal i_sf (0, 1, or above 16) is ignored; the block stays in IDLE.
  - REF: store the chip at ref_buf[chip_idx]. After chip SF-1, go to DATA with chip index 0.
  - DATA: agree += (i_rx == ref_buf[chip_idx]). After chip SF-1, decide the bit, increment bit_idx, and go to REF. After bit 31 the FSM goes to IDLE instead.
- Decision rule: final agreement count A includes the last chip. Bit = 1 if 2*A > SF, else 0. A tie decides 0.
- A 6-bit intermediate is used for 2*A.
- The counter widths are chip_idx 4 bits, bit_idx 5 bits, and agree 5 bits.
- The agree counter clears at every REF entry.
- The decided bit shifts into the LSB of a 32-bit shift register, which shifts left.
- o_msg is loaded from that shift register, including the final bit, only on completion. Otherwise o_msg holds its previous value.
- i_start is ignored while busy. A mid-message i_start does not resynchronise.
- i_sf is sampled only at the accepted start. Later changes have no effect until the next message.

## Timing
- Reset values: o_bit=0, o_bit_valid=0, o_corr=0, o_msg=0, o_msg_valid=0, o_busy=0. FSM goes to IDLE and all counters and buffers clear.
- Reset mid-message aborts immediately. The partial word is discarded and o_msg stays 0 after reset.
- Cycle numbering: the accepted-start cycle is T0. Frame k occupies cycles T0+2kSF through T0+2kSF+2SF-1.
- o_bit, o_corr and o_bit_valid are registered. They appear in the cycle after each frame's last data chip, at T0+2(k+1)SF.
- o_busy rises at T0+1 and falls at T0+64SF.
- o_msg_valid pulses at T0+64SF, coincident with the 32nd o_bit_valid.
- Back-to-back messages are supported. The FSM is in IDLE at T0+64SF, so i_start in that cycle is accepted with zero gap chips.

## Test plan
- SF=4, message 0xA5A5_0F0F, clean channel.
  - o_msg=0xA5A50F0F and o_msg_valid at T0+256.
  - 32 o_bit_valid pulses, each with o_corr of 4 for 1-bits and 0 for 0-bits.
- SF=16, message 0xFFFF_FFFF, then SF=2 with message 0x0000_0001 back-to-back at T0+1024.
  - Both words are recovered.
  - The second o_msg_valid occurs exactly 128 cycles after the first.
- SF=8, message 0x1234_5678, with chips 0-2 of every data half flipped.
  - A=5, so every decision is unchanged and o_msg=0x12345678.
- SF=8, exactly 4 data chips flipped in a 1-bit frame.
  - The tie decides 0, with o_corr=4.
- Illegal SF and busy behaviour.
  - i_start with i_sf=1 or i_sf=17 leaves o_busy=0.
  - i_start pulsed mid-message does not alter timing or result.
- Reset and SF sampling.
  - Assert i_arst_n low at frame 10: all outputs are 0 at once, and o_msg_valid never fires.
  - A fresh start after reset decodes correctly.
  - Changing i_sf mid-message does not affect the result.
